// File: rtl/thiele_coproc_pkg.sv
// Shared types and constants for the Thiele coprocessor responder hub.
package thiele_coproc_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam int CH_LOGIC = 0;
  localparam int CH_PY    = 1;
  localparam int MAX_CH   = 8;
  localparam int CH_IDX_W = 3;
endpackage

// File: rtl/coproc_rr_arbiter.sv
// Combinational round-robin picker: first eligible channel at or after rr_ptr, wrapping mod NUM_CH.
module coproc_rr_arbiter
  import thiele_coproc_pkg::*;
#(
  parameter int NUM_CH = 2
)(
  input  logic [NUM_CH-1:0]   eligible,
  input  logic [CH_IDX_W-1:0] rr_ptr,
  output logic [NUM_CH-1:0]   grant_oh,
  output logic [CH_IDX_W-1:0] grant_idx
);
  logic [MAX_CH-1:0]   elig_pad;
  logic [CH_IDX_W:0]   k;
  logic                found;

  always_comb begin
    elig_pad  = MAX_CH'(eligible);
    grant_idx = '0;
    found     = 1'b0;
    k         = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      // rr_ptr < NUM_CH, so a single subtraction completes the wrap
      k = {1'b0, rr_ptr} + (CH_IDX_W+1)'(i);
      if (k >= (CH_IDX_W+1)'(NUM_CH)) k = k - (CH_IDX_W+1)'(NUM_CH);
      if (!found && elig_pad[k[CH_IDX_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = k[CH_IDX_W-1:0];
      end
    end
    grant_oh = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      grant_oh[j] = found && (grant_idx == CH_IDX_W'(j));
    end
  end
endmodule

// File: rtl/thiele_coproc_hub.sv
// Coprocessor responder hub: one channel served at a time, ack 1+latency cycles after grant; no backpressure.
// Define COPROC_HUB_STATS_EN to build the per-channel service and abort counters.
module thiele_coproc_hub
  import thiele_coproc_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT_W  = 8
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  output logic [NUM_CH-1:0]        ch_ack,
  output logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH*LAT_W-1:0]  cfg_latency,
  input  logic [NUM_CH*DATA_W-1:0] cfg_result,
  output logic                     busy,
  output logic [2:0]               svc_ch,
  output logic [ADDR_W-1:0]        svc_addr,
  output logic [NUM_CH*32-1:0]     ch_count,
  output logic [15:0]              abort_count
);
  state_t              state_q, state_d;
  logic [LAT_W-1:0]    cnt_q, cnt_d;
  logic [CH_IDX_W-1:0] svc_ch_q, svc_ch_d;
  logic [CH_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]   svc_addr_q, svc_addr_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [NUM_CH-1:0]   armed_q, armed_d;
  logic [NUM_CH-1:0]   ack_q, ack_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   data_q [NUM_CH];
  logic [DATA_W-1:0]   data_d [NUM_CH];
  logic                done_hit, abort_hit;

  logic [MAX_CH-1:0]   req_pad;
  logic [ADDR_W-1:0]   addr_arr [MAX_CH];
  logic [LAT_W-1:0]    lat_arr  [MAX_CH];
  logic [DATA_W-1:0]   res_arr  [MAX_CH];

  logic [NUM_CH-1:0]   grant_oh;
  logic [CH_IDX_W-1:0] grant_idx;
  logic                grant_vld;

  // Pad per-channel inputs to MAX_CH so they can be indexed by a full channel index
  always_comb begin
    req_pad = MAX_CH'(ch_req);
    for (int k = 0; k < MAX_CH; k++) begin
      addr_arr[k] = '0;
      lat_arr[k]  = '0;
      res_arr[k]  = '0;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      addr_arr[k] = ch_addr[k*ADDR_W +: ADDR_W];
      lat_arr[k]  = cfg_latency[k*LAT_W +: LAT_W];
      res_arr[k]  = cfg_result[k*DATA_W +: DATA_W];
    end
  end

  coproc_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .eligible  (ch_req & armed_q),
    .rr_ptr    (rr_ptr_q),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx)
  );

  assign grant_vld = |grant_oh;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    svc_ch_d   = svc_ch_q;
    svc_addr_d = svc_addr_q;
    res_d      = res_q;
    rr_ptr_d   = rr_ptr_q;
    busy_d     = busy_q;
    ack_d      = '0;
    armed_d    = armed_q | ~ch_req;
    data_d     = data_q;
    done_hit   = 1'b0;
    abort_hit  = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (grant_vld) begin
          svc_ch_d   = grant_idx;
          svc_addr_d = addr_arr[grant_idx];
          cnt_d      = lat_arr[grant_idx];
          busy_d     = 1'b1;
          if (lat_arr[grant_idx] == '0) begin
            state_d = ACK;
            res_d   = res_arr[grant_idx];
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!req_pad[svc_ch_q]) begin
          abort_hit = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end else if (cnt_q == LAT_W'(1)) begin
          state_d = ACK;
          res_d   = res_arr[svc_ch_q];
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
        end
      end
      ACK: begin
        // Ack pulse is registered here, so the grant path stays idle for this cycle
        done_hit = 1'b1;
        state_d  = IDLE;
        rr_ptr_d = (svc_ch_q == CH_IDX_W'(NUM_CH-1)) ? '0 : svc_ch_q + CH_IDX_W'(1);
      end
      default: state_d = IDLE;
    endcase
    for (int k = 0; k < NUM_CH; k++) begin
      if (svc_ch_q == CH_IDX_W'(k)) begin
        if (done_hit || abort_hit) armed_d[k] = 1'b0;
        if (done_hit) begin
          ack_d[k]  = 1'b1;
          data_d[k] = res_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      svc_ch_q   <= '0;
      svc_addr_q <= '0;
      res_q      <= '0;
      rr_ptr_q   <= '0;
      busy_q     <= 1'b0;
      ack_q      <= '0;
      armed_q    <= '1;
      for (int k = 0; k < NUM_CH; k++) data_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      svc_ch_q   <= svc_ch_d;
      svc_addr_q <= svc_addr_d;
      res_q      <= res_d;
      rr_ptr_q   <= rr_ptr_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      armed_q    <= armed_d;
      for (int k = 0; k < NUM_CH; k++) data_q[k] <= data_d[k];
    end
  end

  assign ch_ack   = ack_q;
  assign busy     = busy_q;
  assign svc_ch   = svc_ch_q;
  assign svc_addr = svc_addr_q;

  always_comb begin
    ch_data = '0;
    for (int k = 0; k < NUM_CH; k++) ch_data[k*DATA_W +: DATA_W] = data_q[k];
  end

`ifdef COPROC_HUB_STATS_EN
  logic [31:0] count_q [NUM_CH];
  logic [31:0] count_d [NUM_CH];
  logic [15:0] abort_q, abort_d;

  always_comb begin
    count_d = count_q;
    abort_d = abort_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (done_hit && svc_ch_q == CH_IDX_W'(k)) count_d[k] = count_q[k] + 32'd1;
    end
    if (abort_hit && abort_q != 16'hFFFF) abort_d = abort_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abort_q <= '0;
      for (int k = 0; k < NUM_CH; k++) count_q[k] <= '0;
    end else begin
      abort_q <= abort_d;
      for (int k = 0; k < NUM_CH; k++) count_q[k] <= count_d[k];
    end
  end

  always_comb begin
    ch_count = '0;
    for (int k = 0; k < NUM_CH; k++) ch_count[k*32 +: 32] = count_q[k];
  end
  assign abort_count = abort_q;
`else
  assign ch_count    = '0;
  assign abort_count = '0;
`endif
endmodule

// File: tb/tb_thiele_coproc_hub.sv
// Directed bench for thiele_coproc_hub: vector table of single services plus contention, held-req, abort and reset sequences.
module tb_thiele_coproc_hub;
  localparam int NUM_CH = 2;

  logic                 clk;
  logic                 rst_n;
  logic [NUM_CH-1:0]    ch_req;
  logic [NUM_CH*32-1:0] ch_addr;
  logic [NUM_CH-1:0]    ch_ack;
  logic [NUM_CH*32-1:0] ch_data;
  logic [NUM_CH*8-1:0]  cfg_latency;
  logic [NUM_CH*32-1:0] cfg_result;
  logic                 busy;
  logic [2:0]           svc_ch;
  logic [31:0]          svc_addr;
  logic [NUM_CH*32-1:0] ch_count;
  logic [15:0]          abort_count;

  thiele_coproc_hub #(.NUM_CH(NUM_CH), .ADDR_W(32), .DATA_W(32), .LAT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ch_req      (ch_req),
    .ch_addr     (ch_addr),
    .ch_ack      (ch_ack),
    .ch_data     (ch_data),
    .cfg_latency (cfg_latency),
    .cfg_result  (cfg_result),
    .busy        (busy),
    .svc_ch      (svc_ch),
    .svc_addr    (svc_addr),
    .ch_count    (ch_count),
    .abort_count (abort_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    int          lat;
    logic [31:0] res;
    logic [31:0] addr;
    int          exp_dly;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_cnt [NUM_CH];
  int exp_abort;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] stat(input int v);
`ifdef COPROC_HUB_STATS_EN
    return 32'(v);
`else
    return 32'(v - v);
`endif
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    ch_req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NUM_CH; k++) exp_cnt[k] = 0;
    exp_abort = 0;
    @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ack"},   64'(ch_ack), 64'd0);
    chk({tag, "_busy"},  64'(busy), 64'd0);
    chk({tag, "_svcch"}, 64'(svc_ch), 64'd0);
    chk({tag, "_addr"},  64'(svc_addr), 64'd0);
    chk({tag, "_data"},  64'(ch_data), 64'd0);
    chk({tag, "_cnt"},   64'(ch_count), 64'd0);
    chk({tag, "_abort"}, 64'(abort_count), 64'd0);
  endtask

  task automatic run_req(input int ch, input int lat, input logic [31:0] res,
                         input logic [31:0] addr, input int exp_dly, input string nm);
    int n;
    n = 0;
    @(negedge clk);
    cfg_latency[ch*8 +: 8]  = lat[7:0];
    cfg_result[ch*32 +: 32] = res;
    ch_addr[ch*32 +: 32]    = addr;
    ch_req[ch]              = 1'b1;
    @(posedge clk); #1;
    chk({nm, "_busy"}, 64'(busy), 64'd1);
    while (n < 300) begin
      @(posedge clk); #1;
      n++;
      if (ch_ack[ch]) break;
    end
    exp_cnt[ch]++;
    chk({nm, "_dly"},   64'(n), 64'(exp_dly));
    chk({nm, "_data"},  64'(ch_data[ch*32 +: 32]), 64'(res));
    chk({nm, "_addr"},  64'(svc_addr), 64'(addr));
    chk({nm, "_svcch"}, 64'(svc_ch), 64'(ch));
    chk({nm, "_cnt"},   64'(ch_count[ch*32 +: 32]), 64'(stat(exp_cnt[ch])));
    @(posedge clk); #1;
    chk({nm, "_pulse"}, 64'(ch_ack[ch]), 64'd0);
    @(negedge clk);
    ch_req[ch] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_pair(input int lat, output int t0, output int t1);
    @(negedge clk);
    cfg_latency = {lat[7:0], lat[7:0]};
    ch_req      = 2'b11;
    t0 = -1;
    t1 = -1;
    @(posedge clk); #1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (ch_ack[0] && t0 < 0) t0 = n;
      if (ch_ack[1] && t1 < 0) t1 = n;
    end
    exp_cnt[0]++;
    exp_cnt[1]++;
    @(negedge clk);
    ch_req = '0;
    repeat (2) @(negedge clk);
  endtask

  vec_t vecs [6];

  initial begin
    int t0, t1, acks;
    rst_n       = 1'b0;
    ch_req      = '0;
    ch_addr     = '0;
    cfg_latency = '0;
    cfg_result  = '0;
    exp_abort   = 0;
    for (int k = 0; k < NUM_CH; k++) exp_cnt[k] = 0;

    vecs[0] = '{ch: 0, lat: 3,   res: 32'hABCD1234, addr: 32'h0000_1000, exp_dly: 4};
    vecs[1] = '{ch: 1, lat: 0,   res: 32'h12345678, addr: 32'h0000_2004, exp_dly: 1};
    vecs[2] = '{ch: 0, lat: 0,   res: 32'hDEADBEEF, addr: 32'h0000_3008, exp_dly: 1};
    vecs[3] = '{ch: 1, lat: 7,   res: 32'hCAFEF00D, addr: 32'h0000_400C, exp_dly: 8};
    vecs[4] = '{ch: 0, lat: 1,   res: 32'h0000_0001, addr: 32'hFFFF_FFFC, exp_dly: 2};
    vecs[5] = '{ch: 1, lat: 255, res: 32'hA5A5A5A5, addr: 32'h8000_0000, exp_dly: 256};

    repeat (3) @(negedge clk);
    chk_reset_state("rst");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_req(vecs[i].ch, vecs[i].lat, vecs[i].res, vecs[i].addr, vecs[i].exp_dly,
              $sformatf("vec%0d", i));
    end

    // Contention from reset: ch0 first, ch1 granted the cycle after ch0's ack
    do_reset();
    run_pair(2, t0, t1);
    chk("pair1_t0", 64'(t0), 64'd3);
    chk("pair1_t1", 64'(t1), 64'd7);
    chk("pair1_cnt", 64'(ch_count), {stat(exp_cnt[1]), stat(exp_cnt[0])});
    run_req(0, 0, 32'h0BAD_F00D, 32'h0000_0040, 1, "solo0");
    run_pair(2, t0, t1);
    chk("pair2_t1", 64'(t1), 64'd3);
    chk("pair2_t0", 64'(t0), 64'd7);

    // Held request: one ack, then re-served only after a one-cycle drop
    @(negedge clk);
    cfg_latency[7:0] = 8'd1;
    ch_req[0] = 1'b1;
    acks = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (ch_ack[0]) acks++;
    end
    chk("held_acks1", 64'(acks), 64'd1);
    @(negedge clk);
    ch_req[0] = 1'b0;
    @(negedge clk);
    ch_req[0] = 1'b1;
    acks = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (ch_ack[0]) acks++;
    end
    exp_cnt[0] += 2;
    chk("held_acks2", 64'(acks), 64'd1);
    chk("held_cnt", 64'(ch_count[31:0]), 64'(stat(exp_cnt[0])));
    @(negedge clk);
    ch_req[0] = 1'b0;
    repeat (2) @(negedge clk);

    // Abort: drop req after 5 WAIT cycles of a latency-10 service
    cfg_latency[7:0] = 8'd10;
    ch_req[0] = 1'b1;
    acks = 0;
    @(posedge clk); #1;
    repeat (5) begin
      @(posedge clk); #1;
      if (ch_ack[0]) acks++;
    end
    @(negedge clk);
    ch_req[0] = 1'b0;
    @(posedge clk); #1;
    exp_abort++;
    chk("abort_busy", 64'(busy), 64'd0);
    for (int n = 0; n < 15; n++) begin
      @(posedge clk); #1;
      if (ch_ack[0]) acks++;
    end
    chk("abort_noack", 64'(acks), 64'd0);
    chk("abort_count", 64'(abort_count), 64'(stat(exp_abort)));
    chk("abort_chcnt", 64'(ch_count[31:0]), 64'(stat(exp_cnt[0])));
    run_req(0, 2, 32'h5555_AAAA, 32'h0000_0080, 3, "recover");

    // Reset during WAIT clears everything and suppresses the pending ack
    @(negedge clk);
    cfg_latency[15:8] = 8'd10;
    ch_req[1] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b0;
    ch_req = '0;
    #1;
    chk_reset_state("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (ch_ack != '0) acks++;
    end
    chk("midrst_noack", 64'(acks), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
